xintf_reg_bridge: RTL and testbench
===================================

Name: xintf_reg_bridge

Overview:
- Parametrised DSP XINTF slave bridge. Maps N_WR write channels (DAC setpoints) and N_RD read channels (encoder counts, direction, turns) onto the asynchronous external bus.
- Successor to the single-DAC / three-encoder XINTF state machine. Adds configurable channel counts, address map and timing, per-channel strobes, unmapped-access error counting, and a release wait that blocks re-triggering while a strobe is held low.
- Sits between the top-level tristate pad (top drives data = data_oe ? data_out : 'z) and the DAC/encoder blocks, all in the clk_150 domain.

Parameters:
- DATA_W, 16, bus data width.
- ADDR_W, 18, bus address width.
- N_WR, 4, number of write channels, 1..16.
- N_RD, 4, number of read channels, 1..16.
- WR_BASE, 18'h010, address of write channel 0.
- WR_STRIDE, 18'h001, address step between write channels.
- RD_BASE, 18'h100, address of read channel 0.
- RD_STRIDE, 18'h100, address step between read channels.
- WR_ACTIVE, 6, cycles spent in WR_ACT, ≥2.
- WR_TRAIL, 4, cycles spent in WR_TRAIL, ≥1.
- RD_ACTIVE, 6, cycles data_oe is held high, ≥1.
- RD_TRAIL, 4, cycles spent in RD_TRAIL, ≥1.
- SYNC_STAGES, 2, synchroniser depth on rd_n, wr_n, addr and data_in, ≥2.
- WR_RST_VAL, 16'h7fff, reset value of every wr_data channel (DAC mid-scale).

Ports:
- clk  in  1  system clock, 150 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rd_n  in  1  XINTF read strobe, asynchronous, active low.
- wr_n  in  1  XINTF write strobe, asynchronous, active low.
- addr  in  ADDR_W  XINTF address, asynchronous.
- data_in  in  DATA_W  bus data sampled from the pad.
- data_out  out  DATA_W  read data to the pad.
- data_oe  out  1  pad output enable.
- rd_data  in  N_RD*DATA_W  read channel values; channel i occupies bits [i*DATA_W +: DATA_W].
- rd_ack  out  N_RD  one-cycle pulse when channel i has been read.
- wr_data  out  N_WR*DATA_W  write channel registers, same packing as rd_data.
- wr_valid  out  N_WR  one-cycle pulse when channel i is updated.
- err_cnt  out  8  saturating count of unmapped accesses.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - wr_data = WR_RST_VAL on all channels.
  - wr_valid, rd_ack, data_oe, err_cnt, busy = 0; data_out = 0.
  - FSM → IDLE; all synchroniser flops = idle level (strobes 1, addr/data 0).
- Synchronisers: all bus inputs pass through SYNC_STAGES flops. Names below with suffix _s are the synchronised values.
- Decode:
  - Write channel i hits when addr_s == WR_BASE + i*WR_STRIDE.
  - Read channel i hits when addr_s == RD_BASE + i*RD_STRIDE.
  - Lowest index wins on overlap. No hit = unmapped.
- FSM states: IDLE, WR_ACT, WR_TRAIL, RD_DEC, RD_ACT, RD_TRAIL, RELEASE.
  - IDLE: wr_s == 0 → WR_ACT; else rd_s == 0 → RD_DEC. Write wins if both are low.
  - WR_ACT: lasts exactly WR_ACTIVE cycles. On the last cycle, addr_s and data_s are captured → WR_TRAIL.
  - WR_TRAIL, first cycle: on a hit, wr_data[i] ← captured data and wr_valid[i] = 1 for that single cycle. Unmapped: no update, err_cnt += 1 (saturates at 255). Total WR_TRAIL cycles → RELEASE.
  - RD_DEC: one cycle. On a hit, data_out ← rd_data[i] (snapshot). Unmapped: data_out ← 0, err_cnt += 1 → RD_ACT.
  - RD_ACT: lasts RD_ACTIVE cycles. data_oe = 1 for every RD_ACT cycle on a hit, 0 if unmapped. data_out is stable for the whole state. rd_ack[i] pulses in the first RD_ACT cycle (hit only) → RD_TRAIL.
  - RD_TRAIL: data_oe = 0; lasts RD_TRAIL cycles → RELEASE.
  - RELEASE: stays until rd_s == 1 and wr_s == 1 → IDLE. A held-low strobe therefore causes exactly one access.
- Outputs are registered. data_oe is decoded from the registered state only (glitch-free).
- Write latency: wr_valid rises SYNC_STAGES + 1 + WR_ACTIVE clocks after the first clk edge that samples wr_n low.
- Only one wr_valid bit and one rd_ack bit may be high at any time.
- Timing counters are sized by $clog2 of the maximum timing parameter and clear on every state entry.

Test Plan:
1. Reset values: rst_n low → wr_data all 16'h7fff, data_oe = 0, err_cnt = 0, busy = 0. Release reset; 20 idle cycles with no change.
2. Write channel 2: addr = 0x012, data = 0x1234, wr_n low 12 cycles → wr_valid = 4'b0100 for one cycle exactly 9 clocks after the first sampling edge. wr_data channel 2 = 0x1234; other channels stay 0x7fff.
3. Read channel 1: rd_data ch1 = 0xBEEF, addr = 0x200, rd_n low 10 cycles → data_oe high 6 consecutive cycles with data_out = 0xBEEF. rd_ack = 4'b0010 pulses once. ch1 changing to 0x0001 during RD_ACT does not alter data_out.
4. Unmapped: write to 0x055, then read 0x3FF → no wr_valid, data_oe stays 0, err_cnt = 2. Then 300 unmapped accesses → err_cnt holds at 255.
5. Held strobe and simultaneous strobes: wr_n held low 100 cycles → exactly one wr_valid pulse, FSM in RELEASE until wr_n rises. rd_n and wr_n fall together → write performed, no read.
6. Reset mid-read: rst_n pulsed low during RD_ACT → data_oe drops to 0 in the same cycle, FSM in IDLE, all wr_data = 0x7fff. The next access completes normally.

Source files
------------

// File: rtl/xintf_reg_bridge.sv
// -----------------------------------------------------------------------------
// xintf_reg_bridge
// Slave bridge between the DSP XINTF asynchronous external bus and on-chip
// DAC setpoint registers (write channels) and encoder values (read channels).
// Everything runs in the clk_150 domain; bus inputs are synchronised first.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_rd_n, i_wr_n   XINTF strobes (asynchronous, active low)
//   i_addr, i_data_in  XINTF address and pad input data (asynchronous)
//   o_data_out, o_data_oe  read data and output enable for the tristate pad
//   i_rd_data        packed read channel values, ch i at [i*DATA_W +: DATA_W]
//   o_rd_ack         one-cycle pulse on the channel that was read
//   o_wr_data        packed write channel registers, same packing
//   o_wr_valid       one-cycle pulse on the channel that was updated
//   o_err_cnt        saturating count of unmapped accesses
//   o_busy           high whenever the FSM is not idle
//   o_state          FSM state for debug / checkers
//                    (0 IDLE, 1 WR_ACT, 2 WR_TRAIL, 3 RD_DEC, 4 RD_ACT,
//                     5 RD_TRAIL, 6 RELEASE)
//
// Handshake: the bus side has no ready; a falling strobe starts exactly one
// access and the FSM then waits in RELEASE until both strobes are high again.
// On the channel side o_wr_valid[i] / o_rd_ack[i] are single-cycle, one-hot
// event pulses with no back-pressure; o_wr_data is valid from the pulse on.
// -----------------------------------------------------------------------------
module xintf_reg_bridge #(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 18,
   parameter int                N_WR        = 4,
   parameter int                N_RD        = 4,
   parameter logic [ADDR_W-1:0] WR_BASE     = ADDR_W'('h010),
   parameter logic [ADDR_W-1:0] WR_STRIDE   = ADDR_W'('h001),
   parameter logic [ADDR_W-1:0] RD_BASE     = ADDR_W'('h100),
   parameter logic [ADDR_W-1:0] RD_STRIDE   = ADDR_W'('h100),
   parameter int                WR_ACTIVE   = 6,
   parameter int                WR_TRAIL    = 4,
   parameter int                RD_ACTIVE   = 6,
   parameter int                RD_TRAIL    = 4,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] WR_RST_VAL  = DATA_W'('h7fff)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_rd_n,
   input  logic                   i_wr_n,
   input  logic [ADDR_W-1:0]      i_addr,
   input  logic [DATA_W-1:0]      i_data_in,
   output logic [DATA_W-1:0]      o_data_out,
   output logic                   o_data_oe,
   input  logic [N_RD*DATA_W-1:0] i_rd_data,
   output logic [N_RD-1:0]        o_rd_ack,
   output logic [N_WR*DATA_W-1:0] o_wr_data,
   output logic [N_WR-1:0]        o_wr_valid,
   output logic [7:0]             o_err_cnt,
   output logic                   o_busy,
   output logic [2:0]             o_state
);

   localparam int T_MAX_A = (WR_ACTIVE > WR_TRAIL) ? WR_ACTIVE : WR_TRAIL;
   localparam int T_MAX_B = (RD_ACTIVE > RD_TRAIL) ? RD_ACTIVE : RD_TRAIL;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_ACT   = 3'd1,
      ST_WR_TRAIL = 3'd2,
      ST_RD_DEC   = 3'd3,
      ST_RD_ACT   = 3'd4,
      ST_RD_TRAIL = 3'd5,
      ST_RELEASE  = 3'd6
   } state_t;

   // synchronisers
   logic [SYNC_STAGES-1:0]             r_rd_sync;
   logic [SYNC_STAGES-1:0]             r_wr_sync;
   logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_addr_sync;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] r_data_sync;
   logic                               w_rd_s;
   logic                               w_wr_s;
   logic [ADDR_W-1:0]                  w_addr_s;
   logic [DATA_W-1:0]                  w_data_s;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [ADDR_W-1:0]      r_cap_addr;
   logic [DATA_W-1:0]      r_cap_data;
   logic [N_WR*DATA_W-1:0] r_wr_data;
   logic [N_WR-1:0]        r_wr_valid;
   logic [N_RD-1:0]        r_rd_ack;
   logic [DATA_W-1:0]      r_data_out;
   logic                   r_rd_hit;
   logic [7:0]             r_err_cnt;

   logic [N_WR-1:0]        w_wr_oh;
   logic [N_RD-1:0]        w_rd_oh;
   logic                   w_wr_hit;
   logic                   w_rd_hit;
   logic [DATA_W-1:0]      w_rd_sel;
   logic                   w_trail_first;
   logic                   w_err_inc;

   assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
   assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
   assign w_addr_s = r_addr_sync[SYNC_STAGES-1];
   assign w_data_s = r_data_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_sync   <= '1;
         r_wr_sync   <= '1;
         r_addr_sync <= '0;
         r_data_sync <= '0;
      end else begin
         r_rd_sync      <= {r_rd_sync[SYNC_STAGES-2:0], i_rd_n};
         r_wr_sync      <= {r_wr_sync[SYNC_STAGES-2:0], i_wr_n};
         r_addr_sync[0] <= i_addr;
         r_data_sync[0] <= i_data_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_addr_sync[k] <= r_addr_sync[k-1];
            r_data_sync[k] <= r_data_sync[k-1];
         end
      end
   end

   // Address decode. Scanning from the top index down lets the lowest
   // matching channel overwrite any higher one, so overlaps resolve low.
   // Writes decode the captured address, reads the live synchronised one.
   always_comb begin
      w_wr_oh  = '0;
      w_rd_oh  = '0;
      w_rd_sel = '0;
      for (int i = N_WR-1; i >= 0; i--) begin
         if (r_cap_addr == WR_BASE + ADDR_W'(i) * WR_STRIDE) begin
            w_wr_oh    = '0;
            w_wr_oh[i] = 1'b1;
         end
      end
      for (int i = N_RD-1; i >= 0; i--) begin
         if (w_addr_s == RD_BASE + ADDR_W'(i) * RD_STRIDE) begin
            w_rd_oh    = '0;
            w_rd_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < N_RD; i++) begin
         if (w_rd_oh[i]) w_rd_sel = i_rd_data[i*DATA_W +: DATA_W];
      end
   end

   assign w_wr_hit = |w_wr_oh;
   assign w_rd_hit = |w_rd_oh;

   always_comb begin
      w_state_next  = r_state;
      w_trail_first = (r_state == ST_WR_TRAIL) && (r_cnt == '0);
      w_err_inc     = (w_trail_first && !w_wr_hit) ||
                      ((r_state == ST_RD_DEC) && !w_rd_hit);
      case (r_state)
         ST_IDLE: begin
            if (!w_wr_s)      w_state_next = ST_WR_ACT;
            else if (!w_rd_s) w_state_next = ST_RD_DEC;
         end
         ST_WR_ACT:   if (r_cnt == CNT_W'(WR_ACTIVE-1)) w_state_next = ST_WR_TRAIL;
         ST_WR_TRAIL: if (r_cnt == CNT_W'(WR_TRAIL-1))  w_state_next = ST_RELEASE;
         ST_RD_DEC:   w_state_next = ST_RD_ACT;
         ST_RD_ACT:   if (r_cnt == CNT_W'(RD_ACTIVE-1)) w_state_next = ST_RD_TRAIL;
         ST_RD_TRAIL: if (r_cnt == CNT_W'(RD_TRAIL-1))  w_state_next = ST_RELEASE;
         ST_RELEASE:  if (w_rd_s && w_wr_s)             w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_cap_addr <= '0;
         r_cap_data <= '0;
         r_wr_data  <= {N_WR{WR_RST_VAL}};
         r_wr_valid <= '0;
         r_rd_ack   <= '0;
         r_data_out <= '0;
         r_rd_hit   <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wr_valid <= '0;
         r_rd_ack   <= '0;
         // the dwell counter restarts on every state entry
         if (w_state_next != r_state) r_cnt <= '0;
         else                         r_cnt <= r_cnt + 1'b1;
         // capture on the last WR_ACT cycle, once the bus has had time to settle
         if ((r_state == ST_WR_ACT) && (w_state_next == ST_WR_TRAIL)) begin
            r_cap_addr <= w_addr_s;
            r_cap_data <= w_data_s;
         end
         if (w_trail_first) begin
            r_wr_valid <= w_wr_oh;
            for (int i = 0; i < N_WR; i++) begin
               if (w_wr_oh[i]) r_wr_data[i*DATA_W +: DATA_W] <= r_cap_data;
            end
         end
         // snapshot of the read channel; w_rd_sel is zero when unmapped
         if (r_state == ST_RD_DEC) begin
            r_data_out <= w_rd_sel;
            r_rd_hit   <= w_rd_hit;
            r_rd_ack   <= w_rd_oh;
         end
         if (w_err_inc && (r_err_cnt != 8'hff)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   // data_oe depends only on flops so the pad enable cannot glitch
   assign o_data_oe  = (r_state == ST_RD_ACT) && r_rd_hit;
   assign o_data_out = r_data_out;
   assign o_rd_ack   = r_rd_ack;
   assign o_wr_data  = r_wr_data;
   assign o_wr_valid = r_wr_valid;
   assign o_err_cnt  = r_err_cnt;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_state    = r_state;

endmodule

// File: tb/tb_xintf_reg_bridge.sv
module tb_xintf_reg_bridge;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RELEASE = 3'd6;
   localparam int         MAX_K      = 400;

   // clock / reset
   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic        rd_n, wr_n;
   logic [17:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_oe;
   logic [63:0] rd_data;
   logic [3:0]  rd_ack;
   logic [63:0] wr_data;
   logic [3:0]  wr_valid;
   logic [7:0]  err_cnt;
   logic        busy;
   logic [2:0]  state;

   xintf_reg_bridge dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rd_n     (rd_n),
      .i_wr_n     (wr_n),
      .i_addr     (addr),
      .i_data_in  (data_in),
      .o_data_out (data_out),
      .o_data_oe  (data_oe),
      .i_rd_data  (rd_data),
      .o_rd_ack   (rd_ack),
      .o_wr_data  (wr_data),
      .o_wr_valid (wr_valid),
      .o_err_cnt  (err_cnt),
      .o_busy     (busy),
      .o_state    (state)
   );

   // scoreboard / reference model
   logic [63:0] exp_q[$];
   logic [63:0] wr_model;
   int          err_model;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // address map: write ch i at 0x010+i, read ch i at 0x100*(i+1)
   function automatic int wr_chan(input logic [17:0] a);
      for (int i = 0; i < 4; i++)
         if (a == 18'h010 + 18'(i)) return i;
      return -1;
   endfunction

   function automatic int rd_chan(input logic [17:0] a);
      for (int i = 0; i < 4; i++)
         if (a == 18'h100 + 18'(i) * 18'h100) return i;
      return -1;
   endfunction

   function automatic logic [17:0] rand_unmapped();
      logic [17:0] a;
      a = 18'($urandom_range(0, 18'h3ffff));
      while (wr_chan(a) >= 0 || rd_chan(a) >= 0) a = 18'($urandom_range(0, 18'h3ffff));
      return a;
   endfunction

   function automatic void bump_err();
      if (err_model < 255) err_model++;
   endfunction

   // driver + monitor for one bus access; strobes held low for 'hold' cycles
   task automatic access(input bit do_wr, input bit do_rd, input logic [17:0] a,
                         input logic [15:0] d, input int hold,
                         input bit do_chg, input logic [15:0] chg_val);
      int          wch, rch, k;
      int          wr_pulses, wr_pulse_k, oe_cnt, oe_first, oe_last, ack_cnt;
      int          bad_data, bad_oh;
      logic [3:0]  ack_val;
      logic [15:0] exp_rd;
      bit          done;
      wch = do_wr ? wr_chan(a) : -1;
      rch = (!do_wr && do_rd) ? rd_chan(a) : -1;
      exp_rd = (rch >= 0) ? rd_data[rch*16 +: 16] : 16'h0;
      if (wch >= 0) exp_q.push_back(64'd1 << wch);
      wr_pulses = 0; wr_pulse_k = -1; oe_cnt = 0; oe_first = -1; oe_last = -1;
      ack_cnt = 0; ack_val = '0; bad_data = 0; bad_oh = 0; done = 0;

      @(negedge clk);
      addr    = a;
      data_in = d;
      wr_n    = !do_wr;
      rd_n    = !do_rd;
      k = 0;
      while (!done && k < MAX_K) begin
         @(negedge clk);
         k++;
         if ($countones(wr_valid) > 1 || $countones(rd_ack) > 1) bad_oh++;
         if (wr_valid != 0) begin
            wr_pulses++;
            if (wr_pulse_k < 0) wr_pulse_k = k;
            if (exp_q.size() > 0) check_eq("wr_valid_val", 64'(wr_valid), exp_q.pop_front());
            else                  check_eq("wr_valid_unexp", 64'(wr_valid), 64'd0);
         end
         if (data_oe) begin
            oe_cnt++;
            if (oe_first < 0) oe_first = k;
            oe_last = k;
            if (data_out !== exp_rd) bad_data++;
         end
         if (rd_ack != 0) begin
            ack_cnt++;
            ack_val = rd_ack;
         end
         if (do_chg && k == 6 && rch >= 0) rd_data[rch*16 +: 16] = chg_val;
         if (hold >= 40 && k == hold - 1) check_eq("held_state", 64'(state), 64'(ST_RELEASE));
         if (k == hold) begin
            wr_n = 1'b1;
            rd_n = 1'b1;
         end
         if (k >= 4 && k > hold + 3 && !busy) done = 1;
      end
      if (!done) check_eq("busy_timeout", 64'(k), 64'(MAX_K + 1));

      if (do_wr) begin
         if (wch >= 0) wr_model[wch*16 +: 16] = d;
         else          bump_err();
      end else if (do_rd && rch < 0) begin
         bump_err();
      end

      check_eq("wr_pulses", 64'(wr_pulses), 64'((wch >= 0) ? 1 : 0));
      if (wch >= 0) check_eq("wr_latency", 64'(wr_pulse_k), 64'd10);
      check_eq("oe_cycles", 64'(oe_cnt), 64'((rch >= 0) ? 6 : 0));
      check_eq("ack_count", 64'(ack_cnt), 64'((rch >= 0) ? 1 : 0));
      if (rch >= 0) begin
         check_eq("oe_first", 64'(oe_first), 64'd4);
         check_eq("oe_contig", 64'(oe_last - oe_first + 1), 64'd6);
         check_eq("ack_val", 64'(ack_val), 64'd1 << rch);
         check_eq("rd_data_out", 64'(bad_data), 64'd0);
      end
      check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
      check_eq("one_hot", 64'(bad_oh), 64'd0);
      check_eq("wr_data", wr_data, wr_model);
      check_eq("err_cnt", 64'(err_cnt), 64'(err_model));
   endtask

   initial begin
      int bad;
      int sel, ch, k;
      logic [17:0] a;
      rst_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; addr = '0; data_in = '0; rd_data = '0;
      wr_model  = {4{16'h7fff}};
      err_model = 0;

      // reset values
      repeat (3) @(negedge clk);
      check_eq("rst_wr_data", wr_data, wr_model);
      check_eq("rst_oe", 64'(data_oe), 64'd0);
      check_eq("rst_err", 64'(err_cnt), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_data_out", 64'(data_out), 64'd0);
      check_eq("rst_pulses", 64'({wr_valid, rd_ack}), 64'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (wr_data !== wr_model || data_oe !== 1'b0 || busy !== 1'b0 ||
             err_cnt !== 8'd0 || wr_valid !== 4'd0 || rd_ack !== 4'd0) bad++;
      end
      check_eq("idle_stable", 64'(bad), 64'd0);

      // write ch2, read ch1 with change during RD_ACT
      access(1, 0, 18'h012, 16'h1234, 12, 0, 16'h0);
      rd_data = {$urandom, $urandom};
      rd_data[16 +: 16] = 16'hBEEF;
      access(0, 1, 18'h200, 16'h0, 10, 1, 16'h0001);

      // unmapped accesses and saturation
      access(1, 0, 18'h055, 16'hAAAA, 10, 0, 16'h0);
      access(0, 1, 18'h3FF, 16'h0, 10, 0, 16'h0);
      for (int n = 0; n < 300; n++) begin
         a = rand_unmapped();
         if ($urandom_range(0, 1) == 1) access(1, 0, a, 16'($urandom), 2, 0, 16'h0);
         else                           access(0, 1, a, 16'h0, 2, 0, 16'h0);
      end
      check_eq("err_saturated", 64'(err_cnt), 64'd255);

      // held strobe, then simultaneous strobes
      access(1, 0, 18'h013, 16'h5A5A, 100, 0, 16'h0);
      access(1, 1, 18'h011, 16'hC3C3, 8, 0, 16'h0);

      // randomized mix
      for (int n = 0; n < 40; n++) begin
         rd_data = {$urandom, $urandom};
         sel = $urandom_range(0, 9);
         ch  = $urandom_range(0, 3);
         if (sel < 4)
            access(1, 0, 18'h010 + 18'(ch), 16'($urandom), $urandom_range(1, 15), 0, 16'h0);
         else if (sel < 8)
            access(0, 1, 18'h100 + 18'(ch) * 18'h100, 16'h0, $urandom_range(1, 15),
                   1, 16'($urandom));
         else if (sel == 8)
            access(0, 1, rand_unmapped(), 16'h0, $urandom_range(1, 15), 0, 16'h0);
         else
            access(1, 1, 18'h010 + 18'(ch), 16'($urandom), $urandom_range(1, 15), 0, 16'h0);
      end

      // reset in the middle of RD_ACT
      rd_data = {$urandom, $urandom};
      @(negedge clk);
      addr = 18'h300;
      rd_n = 1'b0;
      k = 0;
      while (!data_oe && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("pre_rst_oe", 64'(data_oe), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      rd_n  = 1'b1;
      #1;
      wr_model  = {4{16'h7fff}};
      err_model = 0;
      check_eq("midrst_oe", 64'(data_oe), 64'd0);
      check_eq("midrst_state", 64'(state), 64'(ST_IDLE));
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_eq("midrst_wr_data", wr_data, wr_model);
      check_eq("midrst_err", 64'(err_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      access(1, 0, 18'h010, 16'h0F0F, 10, 0, 16'h0);
      rd_data = {$urandom, $urandom};
      access(0, 1, 18'h400, 16'h0, 10, 0, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
